// File: rtl/cnt_evt_capture_pkg.sv
// Register map, bit positions and control bundle of the event-capture
// peripheral.
package cnt_evt_capture_pkg;

    localparam logic [3:0] DATA_OFFS   = 4'h0;
    localparam logic [3:0] STATUS_OFFS = 4'h4;
    localparam logic [3:0] CTRL_OFFS   = 4'h8;
    localparam logic [3:0] TS_OFFS     = 4'hC;

    localparam int unsigned CTRL_EN_BIT      = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT  = 1;
    localparam int unsigned CTRL_OVF_CLR_BIT = 2;
    localparam int unsigned CTRL_FLUSH_BIT   = 3;

    localparam int unsigned STATUS_EMPTY_BIT = 0;
    localparam int unsigned STATUS_FULL_BIT  = 1;
    localparam int unsigned STATUS_OVF_BIT   = 2;
    localparam int unsigned STATUS_CNT_LSB   = 8;
    localparam int unsigned STATUS_CNT_W     = 5;

    typedef struct packed {
        logic irq_en;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/croc_pkg.sv
// Minimal slice of the SoC package: OBI subordinate request/response bundles
// as seen by the peripheral. All response fields not driven here stay zero.
package croc_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [1:0]  aid;
    } sbr_obi_a_chan_t;

    typedef struct packed {
        logic            req;
        sbr_obi_a_chan_t a;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  rid;
        logic        err;
    } sbr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        sbr_obi_r_chan_t r;
    } sbr_obi_rsp_t;

endpackage

// File: rtl/cnt_evt_fifo.sv
// Circular timestamp buffer. Flush beats push/pop; push when full is
// dropped unless a pop frees a slot in the same cycle.
module cnt_evt_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cnt_evt_capture.sv
// Timestamps rising edges of the counter terminal-count level into a FIFO
// that the host drains over an OBI subordinate port.
module cnt_evt_capture
    import cnt_evt_capture_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TS_W  = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   tc_i,
    input  croc_pkg::sbr_obi_req_t obi_req_i,
    output croc_pkg::sbr_obi_rsp_t obi_rsp_o,
    output logic                   irq_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [TS_W-1:0] ts_q;
    logic            tc_q;
    ctrl_t           ctrl_q;
    logic            ovf_q;
    logic            rvalid_q;
    logic [31:0]     rdata_q;
    logic [1:0]      rid_q;

    logic            evt;
    logic            push;
    logic            pop;
    logic            flush;
    logic            ovf_set;
    logic            ovf_clr;
    logic            req;
    logic            rd_req;
    logic            ctrl_wr;
    logic [1:0]      word;
    logic [31:0]     rdata_d;
    logic [31:0]     ts_ext;
    logic [31:0]     head_ext;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    logic [TS_W-1:0] head;
    logic            unused;

    assign req     = obi_req_i.req;
    assign word    = obi_req_i.a.addr[3:2];
    assign rd_req  = req & ~obi_req_i.a.we;
    assign ctrl_wr = req & obi_req_i.a.we & obi_req_i.a.be[0]
                   & (word == CTRL_OFFS[3:2]);

    assign evt     = tc_i & ~tc_q;
    assign push    = evt & ctrl_q.en;
    assign pop     = rd_req & (word == DATA_OFFS[3:2]);
    assign flush   = ctrl_wr & obi_req_i.a.wdata[CTRL_FLUSH_BIT];
    assign ovf_clr = ctrl_wr & obi_req_i.a.wdata[CTRL_OVF_CLR_BIT];
    // A flushed event is simply lost, so it must not count as overflow.
    assign ovf_set = push & full & ~pop & ~flush;

    assign unused = ^{obi_req_i.a.addr[31:4], obi_req_i.a.addr[1:0],
                      obi_req_i.a.wdata[31:4], obi_req_i.a.be[3:1]};

    cnt_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TS_W)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .din    (ts_q),
        .full   (full),
        .empty  (empty),
        .count  (count),
        .head   (head)
    );

    always_comb begin
        ts_ext             = '0;
        ts_ext[TS_W-1:0]   = ts_q;
        head_ext           = '0;
        head_ext[TS_W-1:0] = head;
    end

    always_comb begin
        rdata_d = '0;
        if (rd_req) begin
            unique case (word)
                DATA_OFFS[3:2]: begin
                    if (!empty) rdata_d = head_ext;
                end
                STATUS_OFFS[3:2]: begin
                    rdata_d[STATUS_EMPTY_BIT] = empty;
                    rdata_d[STATUS_FULL_BIT]  = full;
                    rdata_d[STATUS_OVF_BIT]   = ovf_q;
                    rdata_d[STATUS_CNT_LSB +: STATUS_CNT_W] =
                        STATUS_CNT_W'(count);
                end
                CTRL_OFFS[3:2]: begin
                    rdata_d[CTRL_EN_BIT]     = ctrl_q.en;
                    rdata_d[CTRL_IRQ_EN_BIT] = ctrl_q.irq_en;
                end
                TS_OFFS[3:2]: begin
                    rdata_d = ts_ext;
                end
                default: begin
                    rdata_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_q     <= '0;
            tc_q     <= 1'b0;
            ctrl_q   <= '0;
            ovf_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
        end else begin
            ts_q  <= ts_q + TS_W'(1);
            tc_q  <= tc_i;
            ovf_q <= ovf_set | (ovf_q & ~ovf_clr);
            if (ctrl_wr) begin
                ctrl_q.en     <= obi_req_i.a.wdata[CTRL_EN_BIT];
                ctrl_q.irq_en <= obi_req_i.a.wdata[CTRL_IRQ_EN_BIT];
            end
            rvalid_q <= req;
            rdata_q  <= rdata_d;
            rid_q    <= req ? obi_req_i.a.aid : 2'b00;
        end
    end

    always_comb begin
        obi_rsp_o          = '0;
        obi_rsp_o.gnt      = req;
        obi_rsp_o.rvalid   = rvalid_q;
        obi_rsp_o.r.rdata  = rdata_q;
        obi_rsp_o.r.rid    = rid_q;
        obi_rsp_o.r.err    = 1'b0;
    end

    assign irq_o = ctrl_q.irq_en & ~empty;

endmodule

// File: tb/tb_cnt_evt_capture.sv
// Bench for cnt_evt_capture: directed vectors, corner sequences and random
// traffic against a queue-based reference model.
module tb_cnt_evt_capture;
    import croc_pkg::*;
    import cnt_evt_capture_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TS_W  = 32;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         tc    = 1'b0;
    sbr_obi_req_t req;
    sbr_obi_rsp_t rsp;
    logic         irq;

    always #5 clk = ~clk;

    cnt_evt_capture #(
        .DEPTH (DEPTH),
        .TS_W  (TS_W)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .tc_i      (tc),
        .obi_req_i (req),
        .obi_rsp_o (rsp),
        .irq_o     (irq)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, want);
        end
    endtask

    // Reference model: timestamps are a cycle count since reset release,
    // the FIFO is a plain queue.
    int unsigned m_ts  = 0;
    bit          m_tcq = 0;
    bit          m_en  = 0;
    bit          m_ie  = 0;
    bit          m_ovf = 0;
    int unsigned m_q[$];
    bit          exp_rv  = 0;
    logic [31:0] exp_rd  = '0;
    logic [1:0]  exp_rid = '0;
    bit          sb_on   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ts = 0; m_tcq = 0; m_en = 0; m_ie = 0; m_ovf = 0;
            m_q.delete();
            exp_rv = 0; exp_rd = '0; exp_rid = '0;
        end else begin
            bit          evt;
            bit          flush;
            bit          clr;
            bit          set;
            bit          cwr;
            int unsigned sz;
            logic [31:0] rd;
            evt   = tc && !m_tcq;
            m_tcq = tc;
            flush = 0; clr = 0; set = 0; rd = '0;
            sz    = m_q.size();
            cwr   = req.req && req.a.we && req.a.be[0] &&
                    (req.a.addr[3:2] == 2'd2);
            if (req.req && !req.a.we) begin
                case (req.a.addr[3:2])
                    2'd0: if (sz != 0) rd = m_q.pop_front();
                    2'd1: rd = (sz << 8) | (m_ovf ? 4 : 0) |
                               (sz == DEPTH ? 2 : 0) | (sz == 0 ? 1 : 0);
                    2'd2: rd = {30'd0, m_ie, m_en};
                    default: rd = m_ts;
                endcase
            end
            if (cwr) begin
                flush = req.a.wdata[3];
                clr   = req.a.wdata[2];
            end
            if (evt && m_en && !flush) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_ts);
                else set = 1;
            end
            if (flush) m_q.delete();
            if (cwr) begin
                m_en = req.a.wdata[0];
                m_ie = req.a.wdata[1];
            end
            m_ovf   = set || (m_ovf && !clr);
            m_ts    = m_ts + 1;
            exp_rv  = req.req;
            exp_rd  = rd;
            exp_rid = req.a.aid;
        end
    end

    always @(negedge clk) begin
        if (sb_on) begin
            chk("sb_rvalid", {31'd0, rsp.rvalid}, {31'd0, exp_rv});
            if (exp_rv) begin
                chk("sb_rdata", rsp.r.rdata, exp_rd);
                chk("sb_rid", {30'd0, rsp.r.rid}, {30'd0, exp_rid});
                chk("sb_err", {31'd0, rsp.r.err}, 32'd0);
            end
            chk("sb_irq", {31'd0, irq},
                {31'd0, (m_ie && m_q.size() != 0)});
        end
    end

    // One OBI transfer: drive at a falling edge, return at the next one.
    task automatic xfer(input logic we, input logic [3:0] offs,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] d);
        req.req     = 1'b1;
        req.a.we    = we;
        req.a.addr  = {28'd0, offs};
        req.a.wdata = wd;
        req.a.be    = be;
        req.a.aid   = 2'($urandom);
        #1 chk("gnt", {31'd0, rsp.gnt}, 32'd1);
        @(negedge clk);
        req = '0;
        d   = rsp.r.rdata;
        chk("rvalid", {31'd0, rsp.rvalid}, 32'd1);
    endtask

    task automatic pulse(output int unsigned t);
        t  = m_ts;
        tc = 1'b1;
        @(negedge clk);
        tc = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  offs;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rexp;
    } vec_t;

    vec_t        vt[11];
    logic [31:0] d;
    logic [31:0] d0;
    int unsigned t;
    int unsigned tl[$];
    logic [31:0] w;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        req = '0;
        vt = '{
            '{1'b0, STATUS_OFFS, 32'h0, 4'hF, 32'h1},
            '{1'b0, DATA_OFFS,   32'h0, 4'hF, 32'h0},
            '{1'b0, CTRL_OFFS,   32'h0, 4'hF, 32'h0},
            '{1'b1, CTRL_OFFS,   32'h3, 4'hE, 32'h0},
            '{1'b0, CTRL_OFFS,   32'h0, 4'hF, 32'h0},
            '{1'b1, CTRL_OFFS,   32'hF, 4'h1, 32'h0},
            '{1'b0, CTRL_OFFS,   32'h0, 4'hF, 32'h3},
            '{1'b1, STATUS_OFFS, 32'hFF, 4'hF, 32'h0},
            '{1'b0, STATUS_OFFS, 32'h0, 4'hF, 32'h1},
            '{1'b1, CTRL_OFFS,   32'h0, 4'hF, 32'h0},
            '{1'b0, CTRL_OFFS,   32'h0, 4'hF, 32'h0}
        };
        repeat (3) @(negedge clk);
        chk("rst_rvalid", {31'd0, rsp.rvalid}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        sb_on = 1;
        @(negedge clk);

        // Disabled: a pulse must not be captured.
        pulse(t);
        xfer(1'b0, STATUS_OFFS, 32'h0, 4'hF, d);
        chk("t1_status", d, 32'h1);
        chk("t1_irq", {31'd0, irq}, 32'd0);
        xfer(1'b0, DATA_OFFS, 32'h0, 4'hF, d);
        chk("t1_data", d, 32'h0);

        foreach (vt[i]) begin
            xfer(vt[i].we, vt[i].offs, vt[i].wdata, vt[i].be, d);
            chk($sformatf("vec%0d", i), d, vt[i].rexp);
        end

        // Long high level is a single event, stamped 100.
        xfer(1'b1, CTRL_OFFS, 32'h3, 4'hF, d);
        for (int k = 0; k < 300 && m_ts < 100; k++) @(negedge clk);
        n_chk++;
        if (m_ts != 100) begin
            n_err++;
            $display("FAIL t2_align: got %0d, want 100", m_ts);
        end
        tc = 1'b1;
        repeat (5) @(negedge clk);
        tc = 1'b0;
        @(negedge clk);
        xfer(1'b0, STATUS_OFFS, 32'h0, 4'hF, d);
        chk("t2_status", d, 32'h100);
        chk("t2_irq_hi", {31'd0, irq}, 32'd1);
        xfer(1'b0, DATA_OFFS, 32'h0, 4'hF, d);
        chk("t2_data", d, 32'd100);
        chk("t2_irq_lo", {31'd0, irq}, 32'd0);

        // Overflow with DEPTH+1 events.
        tl.delete();
        for (int k = 0; k < 5; k++) begin
            pulse(t);
            tl.push_back(t);
        end
        xfer(1'b0, STATUS_OFFS, 32'h0, 4'hF, d);
        chk("t3_status", d, 32'h406);
        for (int k = 0; k < 4; k++) begin
            xfer(1'b0, DATA_OFFS, 32'h0, 4'hF, d);
            chk($sformatf("t3_data%0d", k), d, tl[k]);
        end
        xfer(1'b1, CTRL_OFFS, 32'h7, 4'hF, d);
        xfer(1'b0, STATUS_OFFS, 32'h0, 4'hF, d);
        chk("t3_ovf_clr", d, 32'h1);

        // Full FIFO, event lands in the DATA-read grant cycle.
        tl.delete();
        for (int k = 0; k < 4; k++) begin
            pulse(t);
            tl.push_back(t);
        end
        tl.push_back(m_ts);
        tc = 1'b1;
        xfer(1'b0, DATA_OFFS, 32'h0, 4'hF, d);
        tc = 1'b0;
        chk("t4_head", d, tl[0]);
        xfer(1'b0, STATUS_OFFS, 32'h0, 4'hF, d);
        chk("t4_status", d, 32'h402);
        for (int k = 1; k < 5; k++) begin
            xfer(1'b0, DATA_OFFS, 32'h0, 4'hF, d);
            chk($sformatf("t4_data%0d", k), d, tl[k]);
        end

        // Back-to-back TS reads.
        req.req    = 1'b1;
        req.a.we   = 1'b0;
        req.a.addr = {28'd0, TS_OFFS};
        req.a.be   = 4'hF;
        #1 chk("t5_gnt0", {31'd0, rsp.gnt}, 32'd1);
        @(negedge clk);
        chk("t5_rv0", {31'd0, rsp.rvalid}, 32'd1);
        d0 = rsp.r.rdata;
        #1 chk("t5_gnt1", {31'd0, rsp.gnt}, 32'd1);
        @(negedge clk);
        req = '0;
        chk("t5_rv1", {31'd0, rsp.rvalid}, 32'd1);
        chk("t5_delta", rsp.r.rdata - d0, 32'd1);

        // Reset with a response outstanding and two entries queued.
        pulse(t);
        pulse(t);
        req.req    = 1'b1;
        req.a.we   = 1'b0;
        req.a.addr = {28'd0, STATUS_OFFS};
        @(posedge clk);
        #2 chk("t6_rv_pend", {31'd0, rsp.rvalid}, 32'd1);
        rst_n = 1'b0;
        #1 chk("t6_rv_drop", {31'd0, rsp.rvalid}, 32'd0);
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, STATUS_OFFS, 32'h0, 4'hF, d);
        chk("t6_status", d, 32'h1);
        xfer(1'b0, CTRL_OFFS, 32'h0, 4'hF, d);
        chk("t6_ctrl", d, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tc = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1) begin
                w = $urandom;
                if ($urandom_range(0, 7) != 0) w[3] = 1'b0;
                if ($urandom_range(0, 3) != 0) w[2] = 1'b0;
                req.req     = 1'b1;
                req.a.we    = ($urandom_range(0, 3) == 0);
                req.a.addr  = $urandom;
                req.a.be    = 4'($urandom);
                req.a.wdata = w;
                req.a.aid   = 2'($urandom);
            end else begin
                req = '0;
            end
            #1 chk("rand_gnt", {31'd0, rsp.gnt}, {31'd0, req.req});
            @(negedge clk);
        end
        req = '0;
        tc  = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
